// File: rtl/host_out_arbiter.sv
// host_out_arbiter
// ----------------
// Two-port arbiter that shares one downstream output handler between two
// response sources. A port raises req and is granted a whole burst of
// count+1 data words. Words are strobed through to the output handler only
// while that port holds the grant and the handler is ready. A burst ends
// after its last word, or when the port stays silent for TIMEOUT_CYCLES
// cycles. Every burst is followed by a single RELEASE cycle with no grant.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   req0/req1                   level requests, held until granted
//   gnt0/gnt1                   registered grants, one-hot or zero
//   status*/address*/count*/data*  per-port response fields
//   en0/en1                     per-port word strobes
//   rdy0/rdy1                   oh_ready qualified by each port's grant
//   oh_ready                    output handler can accept a word
//   oh_en                       word strobe to the output handler
//   out_status/out_address/out_data_count/out_data  granted port's fields
//   timeout                     one-cycle pulse when a grant times out
//   proto_err                   one-cycle pulse when a strobe was dropped
module host_out_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [31:0] status0,
    input  logic [31:0] status1,
    input  logic [31:0] address0,
    input  logic [31:0] address1,
    input  logic [27:0] count0,
    input  logic [27:0] count1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic        en0,
    input  logic        en1,
    output logic        rdy0,
    output logic        rdy1,
    input  logic        oh_ready,
    output logic        oh_en,
    output logic [31:0] out_status,
    output logic [31:0] out_address,
    output logic [27:0] out_data_count,
    output logic [31:0] out_data,
    output logic        timeout,
    output logic        proto_err
);

    // The idle counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            owner_q;      // port holding the current burst (1 = port 1)
    logic            last_q;       // port served by the most recent burst
    logic [27:0]     remaining_q;  // words still owed after the current one
    logic [TW-1:0]   tmo_cnt_q;
    logic            timeout_q;
    logic            proto_err_q;

    logic            acc0_s;
    logic            acc1_s;
    logic            accept_s;
    logic            drop_s;
    logic            pick1_s;

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign timeout   = timeout_q;
    assign proto_err = proto_err_q;

    assign rdy0      = oh_ready & gnt0_q;
    assign rdy1      = oh_ready & gnt1_q;
    assign acc0_s    = en0 & rdy0;
    assign acc1_s    = en1 & rdy1;
    assign accept_s  = acc0_s | acc1_s;
    assign oh_en     = accept_s;

    // Any strobe that is not accepted (handler busy, or port not granted) is lost.
    assign drop_s    = (en0 & ~rdy0) | (en1 & ~rdy1);

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign pick1_s   = req1 & (~req0 | ~last_q);

    // Output field mux: granted port's fields, all zero when nobody is granted.
    always_comb begin
        out_status     = 32'h0000_0000;
        out_address    = 32'h0000_0000;
        out_data_count = 28'h000_0000;
        out_data       = 32'h0000_0000;
        case ({gnt1_q, gnt0_q})
            2'b01: begin
                out_status     = status0;
                out_address    = address0;
                out_data_count = count0;
                out_data       = data0;
            end
            2'b10: begin
                out_status     = status1;
                out_address    = address1;
                out_data_count = count1;
                out_data       = data1;
            end
            default: begin
                out_status     = 32'h0000_0000;
                out_address    = 32'h0000_0000;
                out_data_count = 28'h000_0000;
                out_data       = 32'h0000_0000;
            end
        endcase
    end

    // Arbitration FSM with registered grants and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            remaining_q <= 28'd0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            timeout_q   <= 1'b0;
            proto_err_q <= drop_s;
            case (state_q)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        gnt0_q      <= ~pick1_s;
                        gnt1_q      <= pick1_s;
                        owner_q     <= pick1_s;
                        remaining_q <= pick1_s ? count1 : count0;
                        tmo_cnt_q   <= '0;
                        state_q     <= ST_BURST;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    // Requests are ignored here: the burst runs to completion or timeout.
                    if (accept_s) begin
                        tmo_cnt_q <= '0;
                        if (remaining_q == 28'd0) begin
                            gnt0_q  <= 1'b0;
                            gnt1_q  <= 1'b0;
                            state_q <= ST_RELEASE;
                        end else begin
                            remaining_q <= remaining_q - 28'd1;
                        end
                    end else if (tmo_cnt_q == TMO_LIMIT) begin
                        timeout_q <= 1'b1;
                        gnt0_q    <= 1'b0;
                        gnt1_q    <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= ST_RELEASE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
